// File: rtl/eae_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eae_pkg
// Description : Shared state encoding and operation codes for the extended
//               arithmetic multiply/divide unit.
// Revision    : 1.0  initial release
// ============================================================================
package eae_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } eae_state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage
`default_nettype wire

// File: rtl/eae_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : eae_muldiv_step
// Description : One iteration of the shared datapath. MUL performs an
//               add-and-shift-right on the {hi,lo} product register; DIV
//               performs a shift-left and restoring trial subtract on the
//               {remainder,quotient} register.
// Revision    : 1.0  initial release
// ============================================================================
module eae_muldiv_step
  import eae_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         op,
  input  logic [W-1:0] cur_hi,
  input  logic [W-1:0] cur_lo,
  input  logic [W-1:0] opb,
  output logic [W-1:0] nxt_hi,
  output logic [W-1:0] nxt_lo
);

  logic [W:0] w_mul_sum;
  logic [W:0] w_div_trial;
  logic [W:0] w_div_diff;

  // Single iteration: MUL add/shift or DIV shift/trial-subtract.
  always_comb begin
    // Carry out of the add lands in bit W and shifts into the top of hi.
    w_mul_sum   = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, opb} : '0);
    // Bit shifted out of the remainder is kept as the trial's top bit.
    w_div_trial = {cur_hi, cur_lo[W-1]};
    // Remainder stays below the divisor, so trial < 2*divisor and the
    // difference's top bit is a valid sign bit.
    w_div_diff  = w_div_trial - {1'b0, opb};
    nxt_hi      = '0;
    nxt_lo      = '0;
    if (op == OP_MUL) begin
      nxt_hi = w_mul_sum[W:1];
      nxt_lo = {w_mul_sum[0], cur_lo[W-1:1]};
    end else if (!w_div_diff[W]) begin
      nxt_hi = w_div_diff[W-1:0];
      nxt_lo = {cur_lo[W-2:0], 1'b1};
    end else begin
      nxt_hi = w_div_trial[W-1:0];
      nxt_lo = {cur_lo[W-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/eae_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : eae_muldiv
// Description : Sequential W x W multiply-add and 2W / W restoring divide.
//               Control FSM, iteration counter and the working registers
//               that double as the result registers.
// Revision    : 1.0  initial release
// ============================================================================
module eae_muldiv
  import eae_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] opa_hi,
  input  logic [W-1:0] opa_lo,
  input  logic [W-1:0] opb,
  output logic [W-1:0] result_hi,
  output logic [W-1:0] result_lo,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int               CNT_W    = (W > 2) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  eae_state_t       r_state;
  logic             r_op;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;
  logic [W-1:0]     r_opb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;
  logic [W-1:0]     w_nxt_hi;
  logic [W-1:0]     w_nxt_lo;

  eae_muldiv_step #(
    .W (W)
  ) u_step (
    .op     (r_op),
    .cur_hi (r_hi),
    .cur_lo (r_lo),
    .opb    (r_opb),
    .nxt_hi (w_nxt_hi),
    .nxt_lo (w_nxt_lo)
  );

  // Control FSM; the working registers hold the result once DONE is reached
  // and keep it until the next acceptance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_op       <= OP_MUL;
      r_hi       <= '0;
      r_lo       <= '0;
      r_opb      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_op       <= op;
            r_hi       <= opa_hi;
            r_lo       <= opa_lo;
            r_opb      <= opb;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        LOAD: begin
          r_cnt <= '0;
          // Quotient would not fit in W bits (also catches divide by zero);
          // operands are left untouched as the reported result.
          if (r_op == OP_DIV && r_hi >= r_opb) begin
            r_overflow <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_hi  <= w_nxt_hi;
          r_lo  <= w_nxt_lo;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          // Requester must drop start before another operation is taken.
          if (!start) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign result_hi = r_hi;
  assign result_lo = r_lo;
  assign overflow  = r_overflow;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_eae_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_eae_muldiv
// Description : Scoreboard bench for eae_muldiv at W = 12, 4 and 16. The
//               driver pushes expected results as it issues work; a monitor
//               per instance pops and compares on each rising done.
// Revision    : 1.0  initial release
// ============================================================================
module tb_eae_muldiv;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        ovf;
    logic [15:0] lat;
    logic [15:0] id;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start12 = 1'b0, start4 = 1'b0, start16 = 1'b0;
  logic op_s = 1'b0;
  logic [15:0] ah = '0, al = '0, bb = '0;

  logic [11:0] rh12, rl12;
  logic [3:0]  rh4, rl4;
  logic [15:0] rh16, rl16;
  logic ov12, ov4, ov16, busy12, busy4, busy16, done12, done4, done16;

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  exp_t q12[$], q4[$], q16[$];
  logic busy_q[3];
  logic done_q[3];
  int   acc[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eae_muldiv #(.W(12)) u12 (
    .clock(clk), .reset_n(reset_n), .start(start12), .op(op_s),
    .opa_hi(ah[11:0]), .opa_lo(al[11:0]), .opb(bb[11:0]),
    .result_hi(rh12), .result_lo(rl12), .overflow(ov12), .busy(busy12), .done(done12)
  );
  eae_muldiv #(.W(4)) u4 (
    .clock(clk), .reset_n(reset_n), .start(start4), .op(op_s),
    .opa_hi(ah[3:0]), .opa_lo(al[3:0]), .opb(bb[3:0]),
    .result_hi(rh4), .result_lo(rl4), .overflow(ov4), .busy(busy4), .done(done4)
  );
  eae_muldiv #(.W(16)) u16 (
    .clock(clk), .reset_n(reset_n), .start(start16), .op(op_s),
    .opa_hi(ah), .opa_lo(al), .opb(bb),
    .result_hi(rh16), .result_lo(rl16), .overflow(ov16), .busy(busy16), .done(done16)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else passed++;
  endtask

  function automatic int lane_w(input int l);
    return (l == 0) ? 12 : (l == 1) ? 4 : 16;
  endfunction

  function automatic logic lane_done(input int l);
    return (l == 0) ? done12 : (l == 1) ? done4 : done16;
  endfunction

  function automatic logic lane_busy(input int l);
    return (l == 0) ? busy12 : (l == 1) ? busy4 : busy16;
  endfunction

  function automatic int qsize(input int l);
    return (l == 0) ? q12.size() : (l == 1) ? q4.size() : q16.size();
  endfunction

  task automatic qpush(input int l, input exp_t e);
    case (l)
      0: q12.push_back(e);
      1: q4.push_back(e);
      default: q16.push_back(e);
    endcase
  endtask

  task automatic qpop(input int l, output exp_t e);
    case (l)
      0: e = q12.pop_front();
      1: e = q4.pop_front();
      default: e = q16.pop_front();
    endcase
  endtask

  task automatic set_start(input int l, input logic v);
    case (l)
      0: start12 = v;
      1: start4 = v;
      default: start16 = v;
    endcase
  endtask

  // Monitor: acceptance shows as busy rising; done rising presents a result.
  task automatic monitor_lane(input int l, input logic b, input logic d,
                              input logic [15:0] h, input logic [15:0] lo, input logic ov);
    exp_t e;
    if (b && !busy_q[l]) begin
      acc[l] = cyc;
      check($sformatf("w%0d accept_expected", lane_w(l)), 32'(qsize(l) != 0), 32'd1);
    end
    if (d && !done_q[l]) begin
      check($sformatf("w%0d done_expected", lane_w(l)), 32'(qsize(l) != 0), 32'd1);
      if (qsize(l) != 0) begin
        qpop(l, e);
        check($sformatf("w%0d vec%0d result_hi", lane_w(l), e.id), 32'(h), 32'(e.hi));
        check($sformatf("w%0d vec%0d result_lo", lane_w(l), e.id), 32'(lo), 32'(e.lo));
        check($sformatf("w%0d vec%0d overflow", lane_w(l), e.id), 32'(ov), 32'(e.ovf));
        // Edge count includes the acceptance edge itself.
        check($sformatf("w%0d vec%0d latency", lane_w(l), e.id), 32'(cyc - acc[l] + 1), 32'(e.lat));
      end
    end
    busy_q[l] = b;
    done_q[l] = d;
  endtask

  always @(negedge clk) begin
    monitor_lane(0, busy12, done12, 16'(rh12), 16'(rl12), ov12);
    monitor_lane(1, busy4, done4, 16'(rh4), 16'(rl4), ov4);
    monitor_lane(2, busy16, done16, rh16, rl16, ov16);
  end

  // Issue one operation on lane l; called on a negative edge.
  task automatic run(input int l, input logic o, input logic [15:0] a_hi, input logic [15:0] a_lo,
                     input logic [15:0] b, input logic [15:0] e_hi, input logic [15:0] e_lo,
                     input logic e_ovf, input int id, input int hold, input int gap);
    exp_t e;
    bit   got = 0;
    e.hi  = e_hi;
    e.lo  = e_lo;
    e.ovf = e_ovf;
    e.lat = e_ovf ? 16'd2 : 16'(lane_w(l) + 2);
    e.id  = 16'(id);
    qpush(l, e);
    op_s = o; ah = a_hi; al = a_lo; bb = b;
    set_start(l, 1'b1);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      // Operands are don't-care once accepted.
      if (lane_busy(l)) begin ah = 16'($urandom); al = 16'($urandom); bb = 16'($urandom); end
      if (lane_done(l)) got = 1;
    end
    if (!got) begin
      total++;
      $display("FAIL w%0d vec%0d done_timeout: got done=0 expected done=1", lane_w(l), id);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("w%0d vec%0d done_held", lane_w(l), id), 32'(lane_done(l)), 32'd1);
    end
    set_start(l, 1'b0);
    @(negedge clk);
    check($sformatf("w%0d vec%0d done_drop", lane_w(l), id), 32'(lane_done(l)), 32'd0);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    exp_t dummy;
    bit   seen = 0;
    for (int i = 0; i < 3; i++) begin busy_q[i] = 1'b0; done_q[i] = 1'b0; acc[i] = 0; end
    #12;
    check("reset busy", 32'(busy12), 32'd0);
    check("reset done", 32'(done12), 32'd0);
    check("reset overflow", 32'(ov12), 32'd0);
    check("reset result", 32'({rh12, rl12}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // W = 12 multiply-add
    run(0, 1'b0, 16'd0,    16'd4095, 16'd4095, 16'hFFE, 16'h001, 1'b0, 1, 0, 0);
    run(0, 1'b0, 16'd7,    16'd5,    16'd3,    16'h000, 16'd22,  1'b0, 2, 0, 0);
    run(0, 1'b0, 16'd4095, 16'd4095, 16'd4095, 16'hFFF, 16'h000, 1'b0, 3, 0, 0);
    run(0, 1'b0, 16'd0,    16'd100,  16'd200,  16'h004, 16'hE20, 1'b0, 4, 0, 0);
    // W = 12 divide
    run(0, 1'b1, 16'd0,    16'd100,  16'd7,    16'd2,   16'd14,  1'b0, 5, 0, 0);
    run(0, 1'b1, 16'd3,    16'd0,    16'd4095, 16'd3,   16'd3,   1'b0, 6, 0, 0);
    run(0, 1'b1, 16'd5,    16'd77,   16'd5,    16'd5,   16'd77,  1'b1, 7, 0, 0);
    run(0, 1'b1, 16'd9,    16'd123,  16'd0,    16'd9,   16'd123, 1'b1, 8, 0, 0);
    // Overflow flag must clear on the next acceptance
    run(0, 1'b0, 16'd1,    16'd2,    16'd3,    16'd0,   16'd7,   1'b0, 9, 4, 1);
    run(0, 1'b1, 16'd0,    16'd1000, 16'd10,   16'd0,   16'd100, 1'b0, 10, 0, 0);

    // Reset in the middle of CALC
    begin
      exp_t e;
      e.hi = 16'hFFE; e.lo = 16'h001; e.ovf = 1'b0; e.lat = 16'd14; e.id = 16'd11;
      q12.push_back(e);
      op_s = 1'b0; ah = 16'd0; al = 16'd4095; bb = 16'd4095;
      start12 = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (busy12) seen = 1;
      end
      start12 = 1'b0;
      repeat (6) @(negedge clk);
      check("mid_calc busy_before_reset", 32'(busy12), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("reset busy_async", 32'(busy12), 32'd0);
      check("reset done_async", 32'(done12), 32'd0);
      check("reset overflow_async", 32'(ov12), 32'd0);
      check("reset result_async", 32'({rh12, rl12}), 32'd0);
      if (q12.size() != 0) dummy = q12.pop_front();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
    end
    run(0, 1'b0, 16'd2, 16'd10, 16'd10, 16'd0, 16'd102, 1'b0, 12, 0, 0);

    // W = 4
    run(1, 1'b0, 16'd0, 16'd15, 16'd15, 16'hE, 16'h1, 1'b0, 20, 0, 0);
    run(1, 1'b1, 16'd6, 16'd4,  16'd7,  16'd2, 16'd14, 1'b0, 21, 0, 0);
    run(1, 1'b1, 16'd3, 16'd0,  16'd15, 16'd3, 16'd3,  1'b0, 22, 0, 0);
    run(1, 1'b1, 16'd7, 16'd0,  16'd7,  16'd7, 16'd0,  1'b1, 23, 0, 0);
    // W = 16
    run(2, 1'b0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 30, 0, 0);
    run(2, 1'b1, 16'd0, 16'd100,  16'd7,    16'd2,    16'd14,   1'b0, 31, 0, 0);
    run(2, 1'b1, 16'd3, 16'd0,    16'hFFFF, 16'd3,    16'd3,    1'b0, 32, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard w12 drained", 32'(q12.size()), 32'd0);
    check("scoreboard w4 drained", 32'(q4.size()), 32'd0);
    check("scoreboard w16 drained", 32'(q16.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
